// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and field widths for the watch alarm controller.
package alarm_pkg;
  localparam int TW = 6;
  localparam int CW = 10;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;
endpackage

// File: rtl/alarm_ctrl_sec_countdown.sv
// sec_countdown: tick-driven down counter with synchronous load; saturates at zero.
module sec_countdown
  import alarm_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_tick,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_tick && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm key routing, arm/disarm, time match and bounded buzzer ring.
// Optional snooze state is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic          alarm_mode,
  input  logic          key_minute,
  input  logic          key_hour,
  input  logic          key_arm,
  input  logic          key_stop,
  input  logic [TW-1:0] time_hour,
  input  logic [TW-1:0] time_minute,
  input  logic [TW-1:0] time_second,
  input  logic [TW-1:0] alarm_hour,
  input  logic [TW-1:0] alarm_minute,
  output logic          minute_set,
  output logic          hour_set,
  output logic          armed,
  output logic          ringing,
  output logic          buzzer
);
  if (RING_SECS < 1 || RING_SECS > 1023 || SNOOZE_MINS < 1 || SNOOZE_MINS > 15) begin : g_bad_param
    $error("alarm_ctrl: parameter out of range");
  end
  state_t r_state, w_nxt;
  logic r_match_d, r_phase, w_phase_nxt, w_match, w_trig, w_ring_zero, w_snz_zero;
  assign w_match = (time_hour == alarm_hour) && (time_minute == alarm_minute) && (time_second == '0);
  assign w_trig  = w_match & ~r_match_d;
  sec_countdown u_ring (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_nxt == RINGING && r_state != RINGING),
    .i_load_val (CW'(RING_SECS)),
    .i_tick     (tick_1hz && r_state == RINGING),
    .o_zero     (w_ring_zero)
  );
`ifdef ALARM_SNOOZE_EN
  sec_countdown u_snooze (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_nxt == SNOOZE && r_state != SNOOZE),
    .i_load_val (CW'(SNOOZE_MINS * 60)),
    .i_tick     (tick_1hz && r_state == SNOOZE),
    .o_zero     (w_snz_zero)
  );
`else
  assign w_snz_zero = 1'b0;
`endif
  // Keys outrank the timeout; key_arm outranks every other key.
  always_comb begin
    w_nxt       = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      IDLE:    if (key_arm) w_nxt = ARMED;
      ARMED:
        if (w_trig) begin
          w_nxt       = RINGING;
          w_phase_nxt = 1'b1;
        end else if (key_arm) w_nxt = IDLE;
      RINGING:
        if (key_arm) w_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (key_stop) w_nxt = SNOOZE;
        else if (key_minute || key_hour) w_nxt = ARMED;
`else
        else if (key_stop || key_minute || key_hour) w_nxt = ARMED;
`endif
        else if (w_ring_zero) w_nxt = ARMED;
        else if (tick_1hz) w_phase_nxt = ~r_phase;
`ifdef ALARM_SNOOZE_EN
      SNOOZE:
        if (key_arm) w_nxt = IDLE;
        else if (key_stop) w_nxt = ARMED;
        else if (w_snz_zero) begin
          w_nxt       = RINGING;
          w_phase_nxt = 1'b1;
        end
`endif
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state    <= IDLE;
      r_match_d  <= 1'b0;
      r_phase    <= 1'b0;
      minute_set <= 1'b0;
      hour_set   <= 1'b0;
      armed      <= 1'b0;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_match_d  <= w_match;
      r_phase    <= w_phase_nxt;
      minute_set <= alarm_mode & key_minute & (r_state != RINGING);
      hour_set   <= alarm_mode & key_hour & (r_state != RINGING);
      armed      <= (w_nxt != IDLE);
      ringing    <= (w_nxt == RINGING);
      buzzer     <= (w_nxt == RINGING) & w_phase_nxt;
    end
endmodule
